// File: rtl/lifo_stack.sv
// Parametrised LIFO stack: count-based pointer, registered data output,
// overflow/underflow pulses with sticky error flags and atomic replace-top.
module lifo_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  output logic              err_ovf,
  output logic              err_udf
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] dout_r;
  logic              dout_valid_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              err_ovf_r;
  logic              err_udf_r;

  logic              empty_s;
  logic              full_s;
  logic [AW-1:0]     top_idx_s;
  logic [AW-1:0]     wr_idx_s;
  logic [DATA_W-1:0] top_s;
  logic              rd_ok_s;
  logic              rd_rej_s;
  logic              replace_s;
  logic              push_ok_s;
  logic              ovf_s;
  logic              wr_en_s;
  logic [CNT_W-1:0]  count_nxt_s;

  // Command decode; a pop alongside a push turns it into replace-top,
  // except on an empty stack where the push proceeds and the pop is rejected.
  always_comb begin
    empty_s     = (count_r == {CNT_W{1'b0}});
    full_s      = (count_r == CNT_W'(DEPTH));
    top_idx_s   = count_r[AW-1:0] - AW'(1);
    top_s       = mem_r[top_idx_s];
    rd_ok_s     = (pop | tos) & ~empty_s;
    rd_rej_s    = (pop | tos) & empty_s;
    replace_s   = push & pop & ~empty_s;
    ovf_s       = push & ~pop & full_s;
    push_ok_s   = 1'b0;
    count_nxt_s = count_r;
    if (pop) begin
      push_ok_s = push & empty_s;
    end else begin
      push_ok_s = push & ~full_s;
    end
    if (push_ok_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop & ~push & ~empty_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
    wr_en_s  = (push_ok_s | replace_s) & ~rst;
    wr_idx_s = replace_s ? top_idx_s : count_r[AW-1:0];
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_idx_s] <= din;
    end
  end

  // Occupancy, output register, pulses and sticky flags (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r      <= {CNT_W{1'b0}};
      dout_r       <= {DATA_W{1'b0}};
      dout_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      err_ovf_r    <= 1'b0;
      err_udf_r    <= 1'b0;
    end else begin
      count_r      <= count_nxt_s;
      dout_valid_r <= rd_ok_s;
      overflow_r   <= ovf_s;
      underflow_r  <= rd_rej_s;
      err_ovf_r    <= ovf_s | (err_ovf_r & ~clr_err);
      err_udf_r    <= rd_rej_s | (err_udf_r & ~clr_err);
      if (rd_ok_s) begin
        dout_r <= top_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign full       = full_s;
  assign empty      = empty_s;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;
  assign err_ovf    = err_ovf_r;
  assign err_udf    = err_udf_r;

endmodule
